// File: rtl/fb_write_scheduler.sv
// Single-port framebuffer write scheduler: round-robin between paint and cursor
// requesters, with a top-priority raster-order screen-clear sweep.
module fb_write_scheduler #(
  parameter int unsigned W      = 640,
  parameter int unsigned H      = 480,
  parameter logic [7:0]  CLR_GS = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_req,
  output logic        clr_busy,
  input  logic        paint_valid,
  input  logic [10:0] paint_x,
  input  logic [10:0] paint_y,
  input  logic [7:0]  paint_gs,
  output logic        paint_ready,
  input  logic        cur_valid,
  input  logic [10:0] cur_x,
  input  logic [10:0] cur_y,
  input  logic [7:0]  cur_gs,
  output logic        cur_ready,
  output logic [10:0] fb_x,
  output logic [10:0] fb_y,
  output logic [7:0]  fb_pixel_GS,
  output logic        fb_pixel_write,
  output logic [1:0]  grant,
  output logic [7:0]  oob_count
);

  localparam int unsigned CW = 11;
  localparam logic [CW-1:0] X_LIM = CW'(W);
  localparam logic [CW-1:0] Y_LIM = CW'(H);
  localparam logic [CW-1:0] X_MAX = CW'(W - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(H - 1);

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_CLEAR = 2'b01;
  localparam logic [1:0] GNT_PAINT = 2'b10;
  localparam logic [1:0] GNT_CUR   = 2'b11;

  localparam logic SRC_PAINT = 1'b0;
  localparam logic SRC_CUR   = 1'b1;

  typedef enum logic {SERVE, CLEAR} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cx, cy;
  logic            last;
  logic            sweep_done;

  logic            wr_en;
  logic [CW-1:0]   wr_x, wr_y;
  logic [7:0]      wr_gs;
  logic [1:0]      wr_grant;
  logic            oob_hit;

  assign sweep_done = (cx == X_MAX) && (cy == Y_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= SERVE;
    else       state <= next_state;
  end

  // Next-state logic; clr_req is only looked at from SERVE
  always_comb begin
    next_state = state;
    case (state)
      SERVE:   if (clr_req) next_state = CLEAR;
      CLEAR:   if (sweep_done) next_state = SERVE;
      default: next_state = SERVE;
    endcase
  end

  // Handshake, arbitration and write issue for this cycle
  always_comb begin
    paint_ready = 1'b0;
    cur_ready   = 1'b0;
    wr_en       = 1'b0;
    wr_x        = cx;
    wr_y        = cy;
    wr_gs       = CLR_GS;
    wr_grant    = GNT_NONE;
    oob_hit     = 1'b0;
    if (!reset) begin
      case (state)
        SERVE: begin
          if (!clr_req) begin
            if (paint_valid && (!cur_valid || last == SRC_CUR)) paint_ready = 1'b1;
            else if (cur_valid)                                  cur_ready   = 1'b1;
          end
          if (paint_ready) begin
            wr_x  = paint_x;
            wr_y  = paint_y;
            wr_gs = paint_gs;
            if (paint_x < X_LIM && paint_y < Y_LIM) begin
              wr_en    = 1'b1;
              wr_grant = GNT_PAINT;
            end else begin
              oob_hit = 1'b1;
            end
          end else if (cur_ready) begin
            wr_x  = cur_x;
            wr_y  = cur_y;
            wr_gs = cur_gs;
            if (cur_x < X_LIM && cur_y < Y_LIM) begin
              wr_en    = 1'b1;
              wr_grant = GNT_CUR;
            end else begin
              oob_hit = 1'b1;
            end
          end
        end
        CLEAR: begin
          wr_en    = 1'b1;
          wr_grant = GNT_CLEAR;
        end
        default: ;
      endcase
    end
  end

  // Sweep counters, round-robin pointer and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      cx             <= '0;
      cy             <= '0;
      last           <= SRC_CUR;
      clr_busy       <= 1'b0;
      fb_x           <= '0;
      fb_y           <= '0;
      fb_pixel_GS    <= '0;
      fb_pixel_write <= 1'b0;
      grant          <= GNT_NONE;
      oob_count      <= '0;
    end else begin
      if (state == CLEAR) begin
        if (cx == X_MAX) begin
          cx <= '0;
          cy <= cy + CW'(1);
        end else begin
          cx <= cx + CW'(1);
        end
      end else begin
        cx <= '0;
        cy <= '0;
      end
      if (paint_ready && paint_valid) last <= SRC_PAINT;
      else if (cur_ready && cur_valid) last <= SRC_CUR;
      clr_busy       <= (next_state == CLEAR);
      fb_pixel_write <= wr_en;
      grant          <= wr_grant;
      if (wr_en) begin
        fb_x        <= wr_x;
        fb_y        <= wr_y;
        fb_pixel_GS <= wr_gs;
      end
      if (oob_hit && oob_count != 8'hFF) oob_count <= oob_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler on a 4x3 frame with hand-computed expectations.
module tb_fb_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_req;
  logic        clr_busy;
  logic        paint_valid;
  logic [10:0] paint_x, paint_y;
  logic [7:0]  paint_gs;
  logic        paint_ready;
  logic        cur_valid;
  logic [10:0] cur_x, cur_y;
  logic [7:0]  cur_gs;
  logic        cur_ready;
  logic [10:0] fb_x, fb_y;
  logic [7:0]  fb_pixel_GS;
  logic        fb_pixel_write;
  logic [1:0]  grant;
  logic [7:0]  oob_count;

  int n_checks = 0;
  int n_fail   = 0;

  fb_write_scheduler #(.W(4), .H(3), .CLR_GS(8'h00)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .clr_busy(clr_busy),
    .paint_valid(paint_valid), .paint_x(paint_x), .paint_y(paint_y),
    .paint_gs(paint_gs), .paint_ready(paint_ready),
    .cur_valid(cur_valid), .cur_x(cur_x), .cur_y(cur_y), .cur_gs(cur_gs),
    .cur_ready(cur_ready),
    .fb_x(fb_x), .fb_y(fb_y), .fb_pixel_GS(fb_pixel_GS),
    .fb_pixel_write(fb_pixel_write), .grant(grant), .oob_count(oob_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; registered outputs then show its effect
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit done;
    reset = 1'b1; clr_req = 1'b0;
    paint_valid = 1'b1; paint_x = '0; paint_y = '0; paint_gs = '0;
    cur_valid = 1'b0; cur_x = '0; cur_y = '0; cur_gs = '0;
    #1;
    check("paint_ready_in_reset", 32'(paint_ready), 32'd0);
    tick(); tick();
    check("paint_ready_in_reset2", 32'(paint_ready), 32'd0);
    paint_valid = 1'b0;
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_write", 32'(fb_pixel_write), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_busy",  32'(clr_busy), 32'd0);
      check("idle_xy_gs_oob", {fb_x, fb_y, fb_pixel_GS, oob_count[1:0]}, 32'd0);
    end

    // Single paint pixel
    paint_valid = 1'b1; paint_x = 11'd2; paint_y = 11'd1; paint_gs = 8'h80;
    #1;
    check("paint_ready_single", 32'(paint_ready), 32'd1);
    check("cur_ready_single",   32'(cur_ready), 32'd0);
    tick();
    paint_valid = 1'b0;
    check("paint_write", 32'(fb_pixel_write), 32'd1);
    check("paint_x",     32'(fb_x), 32'd2);
    check("paint_y",     32'(fb_y), 32'd1);
    check("paint_gs",    32'(fb_pixel_GS), 32'h80);
    check("paint_grant", 32'(grant), 32'd2);
    tick();
    check("after_write", 32'(fb_pixel_write), 32'd0);
    check("after_grant", 32'(grant), 32'd0);
    check("hold_x",      32'(fb_x), 32'd2);
    check("hold_gs",     32'(fb_pixel_GS), 32'h80);

    // Single cursor pixel; leaves last = cursor
    cur_valid = 1'b1; cur_x = 11'd3; cur_y = 11'd2; cur_gs = 8'h40;
    #1;
    check("cur_ready_single", 32'(cur_ready), 32'd1);
    tick();
    cur_valid = 1'b0;
    check("cur_write", {fb_pixel_write, grant, 8'(fb_x), 8'(fb_y), fb_pixel_GS}, {23'h0, 1'b1, 2'd3, 8'd3, 8'd2, 8'h40} );

    // Both valid held for four cycles: strict alternation starting with paint
    paint_valid = 1'b1; paint_x = 11'd1; paint_y = 11'd1; paint_gs = 8'h11;
    cur_valid   = 1'b1; cur_x   = 11'd0; cur_y   = 11'd2; cur_gs   = 8'h22;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_paint_ready", 32'(paint_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_cur_ready",   32'(cur_ready),   (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("rr_grant", 32'(grant), (i % 2 == 0) ? 32'd2 : 32'd3);
      check("rr_gs",    32'(fb_pixel_GS), (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    paint_valid = 1'b0; cur_valid = 1'b0;

    // Clear pulse beats a simultaneous paint request; paint waits out the sweep
    tick();
    clr_req = 1'b1;
    paint_valid = 1'b1; paint_x = 11'd3; paint_y = 11'd0; paint_gs = 8'h55;
    #1;
    check("clr_blocks_paint", 32'(paint_ready), 32'd0);
    tick();
    clr_req = 1'b0;
    check("clr_first_nowrite", 32'(fb_pixel_write), 32'd0);
    for (int k = 0; k < 12; k++) begin
      check("clr_busy", 32'(clr_busy), 32'd1);
      check("clr_no_ready", 32'({paint_ready, cur_ready}), 32'd0);
      tick();
      check("clr_write", 32'(fb_pixel_write), 32'd1);
      check("clr_grant", 32'(grant), 32'd1);
      check("clr_x",     32'(fb_x), 32'(k % 4));
      check("clr_y",     32'(fb_y), 32'(k / 4));
      check("clr_gs",    32'(fb_pixel_GS), 32'h00);
    end
    check("clr_busy_end", 32'(clr_busy), 32'd0);
    check("pending_paint_ready", 32'(paint_ready), 32'd1);
    tick();
    paint_valid = 1'b0;
    check("pending_paint_write", {fb_pixel_write, grant, 8'(fb_x), 8'(fb_y), fb_pixel_GS}, {23'h0, 1'b1, 2'd2, 8'd3, 8'd0, 8'h55});

    // Out-of-bounds drops: x = W, then y = H, then saturation
    cur_valid = 1'b1; cur_x = 11'd4; cur_y = 11'd0; cur_gs = 8'h99;
    #1;
    check("oob_cur_ready", 32'(cur_ready), 32'd1);
    tick();
    cur_valid = 1'b0;
    check("oob_no_write", 32'(fb_pixel_write), 32'd0);
    check("oob_grant",    32'(grant), 32'd0);
    check("oob_count1",   32'(oob_count), 32'd1);
    check("oob_hold_x",   32'(fb_x), 32'd3);
    paint_valid = 1'b1; paint_x = 11'd0; paint_y = 11'd3; paint_gs = 8'h77;
    #1;
    check("oob_paint_ready", 32'(paint_ready), 32'd1);
    tick();
    paint_valid = 1'b0;
    check("oob_y_no_write", 32'(fb_pixel_write), 32'd0);
    check("oob_count2",     32'(oob_count), 32'd2);
    cur_valid = 1'b1;
    for (int i = 0; i < 299; i++) tick();
    cur_valid = 1'b0;
    check("oob_saturate", 32'(oob_count), 32'd255);
    check("oob_sat_gs_hold", 32'(fb_pixel_GS), 32'h55);

    // Reset aborts a sweep after five pixels; a new clear restarts at (0,0)
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("pre_reset_x", 32'(fb_x), 32'd0);
    check("pre_reset_y", 32'(fb_y), 32'd1);
    reset = 1'b1; cur_valid = 1'b1; cur_x = 11'd1; cur_y = 11'd1;
    #1;
    check("cur_ready_in_reset", 32'(cur_ready), 32'd0);
    tick();
    reset = 1'b0; cur_valid = 1'b0;
    check("rst_no_write", 32'(fb_pixel_write), 32'd0);
    check("rst_busy",     32'(clr_busy), 32'd0);
    check("rst_oob",      32'(oob_count), 32'd0);
    tick();
    check("post_rst_write", 32'(fb_pixel_write), 32'd0);
    check("post_rst_busy",  32'(clr_busy), 32'd0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("restart_busy", 32'(clr_busy), 32'd1);
    tick();
    check("restart_px0", {fb_pixel_write, grant, 8'(fb_x), 8'(fb_y)}, {21'h0, 1'b1, 2'd1, 8'd0, 8'd0});
    tick();
    check("restart_px1", {8'(fb_x), 8'(fb_y)}, {16'h0, 8'd1, 8'd0});

    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (!clr_busy) done = 1'b1;
    end
    check("restart_completes", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
